instr_prefetch_unit: RTL and testbench

- Front-end fetch stage that sits directly upstream of the IF/ID pipeline register.
- Fetches 16-bit instructions from an instruction memory with variable latency, using a req/ack handshake.
- Buffers fetched instructions in a small FIFO and presents one instruction plus its PC+2 per cycle to IF/ID.
- Honours pipeline stalls (IF/ID write disabled) and branch/jump redirects raised from EX.

---
 rtl/pf_pkg.sv | 19 +
 rtl/pf_fifo.sv | 82 ++++++++
 rtl/instr_prefetch_unit.sv | 123 ++++++++++++
 tb/tb_instr_prefetch_unit.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pf_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package pf_pkg;

    localparam int unsigned XLEN      = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_STEP   = 16'd2;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DISCARD
    } pf_state_t;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_plus2;
    } pf_entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Instruction FIFO with a registered head entry; head reads as all-zero when empty.
module pf_fifo
    import pf_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  pf_entry_t                din_i,
    output pf_entry_t                dout_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     empty_o,
    output logic                     full_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    pf_entry_t         mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q;
    logic [AW-1:0]     wr_ptr_q;
    logic [CW-1:0]     count_q;
    logic [CW-1:0]     count_d;
    pf_entry_t         head_q;
    pf_entry_t         head_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Next head: the entry behind the current head, or the incoming word when it lands on an empty slot.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        if (flush_i) begin
            count_d = '0;
            head_d  = '0;
        end else begin
            count_d = count_q + CW'(do_push) - CW'(do_pop);
            if (count_d == '0) begin
                head_d = '0;
            end else if ((count_q == '0) || (do_pop && (count_q == CW'(1)))) begin
                head_d = din_i;
            end else if (do_pop) begin
                head_d = mem_q[rd_ptr_q + AW'(1)];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            if (flush_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
                if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!flush_i && do_push) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/instr_prefetch_unit.sv
// Fetch stage: single-outstanding imem request FSM feeding a small FIFO toward IF/ID,
// with stall back-pressure and EX redirect flush.
module instr_prefetch_unit
    import pf_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [15:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [15:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [15:0] imem_data_i,
    output logic [15:0] instr_o,
    output logic [15:0] pc_plus2_o,
    output logic        instr_valid_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    pf_state_t     state_q;
    logic [15:0]   fetch_pc_q;
    logic [15:0]   addr_q;
    logic          req_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    pf_entry_t     fifo_din;
    pf_entry_t     fifo_head;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] count_next;
    logic          fifo_empty;
    logic          fifo_full;
    logic          outstanding;
    logic [15:0]   pc_inc;
    logic [15:0]   redir_pc;

    assign outstanding = (state_q != IDLE);
    assign pc_inc      = fetch_pc_q + PC_STEP;
    assign redir_pc    = {redirect_pc_i[15:1], 1'b0};
    assign fifo_flush  = redirect_i;
    assign fifo_push   = (state_q == REQ) && imem_ack_i && !redirect_i;
    assign fifo_pop    = !fifo_empty && !stall_i && !redirect_i;
    assign fifo_din    = '{instr: imem_data_i, pc_plus2: pc_inc};
    assign count_next  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);

    pf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .din_i   (fifo_din),
        .dout_o  (fifo_head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Request FSM; req/addr only move on entering REQ so they stay stable until the ack.
    always_ff @(posedge clk_i) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc_q <= redir_pc;
            if (outstanding && !imem_ack_i) begin
                state_q <= DISCARD;
            end else begin
                state_q <= REQ;
                req_q   <= 1'b1;
                addr_q  <= redir_pc;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_full || fifo_pop) begin
                        state_q <= REQ;
                        req_q   <= 1'b1;
                        addr_q  <= fetch_pc_q;
                    end
                end
                REQ: begin
                    if (imem_ack_i) begin
                        fetch_pc_q <= pc_inc;
                        if (count_next < CW'(DEPTH)) begin
                            addr_q <= pc_inc;
                        end else begin
                            state_q <= IDLE;
                            req_q   <= 1'b0;
                        end
                    end
                end
                DISCARD: begin
                    if (imem_ack_i) begin
                        state_q <= REQ;
                        addr_q  <= fetch_pc_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = req_q;
    assign imem_addr_o   = addr_q;
    assign instr_valid_o = !fifo_empty;
    assign instr_o       = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign pc_plus2_o    = fifo_head.pc_plus2;

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Directed bench for instr_prefetch_unit: queue-based reference model checked every cycle,
// plus literal expectations at the scenario milestones.
module tb_instr_prefetch_unit;
    import pf_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        stall_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        imem_req_o;
    logic [15:0] imem_addr_o;
    logic        imem_ack_i;
    logic [15:0] imem_data_i;
    logic [15:0] instr_o;
    logic [15:0] pc_plus2_o;
    logic        instr_valid_o;

    always #5 clk_i = ~clk_i;

    instr_prefetch_unit #(
        .DEPTH    (DEPTH),
        .RESET_PC (16'h0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_o       (instr_o),
        .pc_plus2_o    (pc_plus2_o),
        .instr_valid_o (instr_valid_o)
    );

    int checks = 0;
    int errors = 0;

    // memory environment
    int          lat      = 0;
    int          wait_cnt = 0;
    bit          manual   = 1'b0;
    bit          man_ack  = 1'b0;
    logic [15:0] man_data = 16'h0000;
    bit          beef_watch = 1'b0;

    // reference model
    pf_entry_t   m_q[$];
    bit          m_pend;
    bit          m_disc;
    logic [15:0] m_pc;
    logic [15:0] m_addr;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of the fetch-stage contract, in queue terms.
    task automatic model_step();
        bit pop;
        if (!rst_n) begin
            m_q.delete();
            m_pc   = 16'h0000;
            m_addr = 16'h0000;
            m_pend = 1'b0;
            m_disc = 1'b0;
            return;
        end
        pop = (m_q.size() > 0) && !stall_i && !redirect_i;
        if (redirect_i) begin
            m_q.delete();
            m_pc = redirect_pc_i & 16'hFFFE;
            if (m_pend && !imem_ack_i) begin
                m_disc = 1'b1;
            end else begin
                m_pend = 1'b1;
                m_disc = 1'b0;
                m_addr = m_pc;
            end
        end else begin
            if (pop) void'(m_q.pop_front());
            if (m_pend && imem_ack_i) begin
                if (m_disc) begin
                    m_disc = 1'b0;
                    m_addr = m_pc;
                end else begin
                    m_q.push_back('{instr: imem_data_i, pc_plus2: m_pc + 16'd2});
                    m_pc = m_pc + 16'd2;
                    if (m_q.size() < DEPTH) m_addr = m_pc;
                    else                    m_pend = 1'b0;
                end
            end else if (!m_pend && (m_q.size() < DEPTH)) begin
                m_pend = 1'b1;
                m_addr = m_pc;
            end
        end
    endtask

    task automatic tick();
        if (manual) begin
            imem_ack_i  = man_ack;
            imem_data_i = man_data;
            wait_cnt    = 0;
        end else if (imem_req_o === 1'b1) begin
            if (wait_cnt >= lat) begin
                imem_ack_i  = 1'b1;
                imem_data_i = mem_word(imem_addr_o);
                wait_cnt    = 0;
            end else begin
                imem_ack_i  = 1'b0;
                imem_data_i = 16'h0000;
                wait_cnt++;
            end
        end else begin
            imem_ack_i  = 1'b0;
            imem_data_i = 16'h0000;
            wait_cnt    = 0;
        end
        #1;
        chk("fifo_no_overflow", 16'(dut.u_fifo.push_i && dut.u_fifo.full_o && !dut.u_fifo.flush_i), 16'h0);
        model_step();
        @(posedge clk_i);
        #1;
        chk("req",   16'(imem_req_o),    16'(m_pend));
        chk("addr",  imem_addr_o,        m_addr);
        chk("valid", 16'(instr_valid_o), 16'(m_q.size() > 0));
        chk("instr", instr_o,            (m_q.size() > 0) ? m_q[0].instr    : 16'h0000);
        chk("pc2",   pc_plus2_o,         (m_q.size() > 0) ? m_q[0].pc_plus2 : 16'h0000);
        if (beef_watch) chk("no_beef", 16'(instr_o == 16'hBEEF), 16'h0);
    endtask

    initial begin
        rst_n = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = 16'h0000;
        imem_ack_i = 1'b0; imem_data_i = 16'h0000;

        // reset, then zero-wait streaming
        tick(); tick();
        chk("rst_req", 16'(imem_req_o), 16'h0);
        chk("rst_addr", imem_addr_o, 16'h0000);
        chk("rst_valid", 16'(instr_valid_o), 16'h0);
        rst_n = 1'b1; lat = 0;
        tick();
        chk("t1_req0", 16'(imem_req_o), 16'h1);
        chk("t1_addr0", imem_addr_o, 16'h0000);
        chk("t1_valid_late", 16'(instr_valid_o), 16'h0);
        tick();
        chk("t1_addr2", imem_addr_o, 16'h0002);
        chk("t1_valid", 16'(instr_valid_o), 16'h1);
        chk("t1_pc2_2", pc_plus2_o, 16'h0002);
        chk("t1_instr", instr_o, 16'h5A5A);
        tick();
        chk("t1_addr4", imem_addr_o, 16'h0004);
        chk("t1_pc2_4", pc_plus2_o, 16'h0004);
        tick();
        chk("t1_addr6", imem_addr_o, 16'h0006);
        chk("t1_pc2_6", pc_plus2_o, 16'h0006);

        // 3-cycle memory with the consumer stalled fills the FIFO
        rst_n = 1'b0; tick();
        rst_n = 1'b1; lat = 3; stall_i = 1'b1;
        repeat (30) tick();
        chk("t2_req_drop", 16'(imem_req_o), 16'h0);
        chk("t2_count", 16'(dut.u_fifo.count_o), 16'd4);
        chk("t2_model_fill", 16'(m_q.size()), 16'd4);
        chk("t2_head", pc_plus2_o, 16'h0002);
        stall_i = 1'b0;
        tick();
        chk("t2_pop1", pc_plus2_o, 16'h0004);
        chk("t2_resume_req", 16'(imem_req_o), 16'h1);
        chk("t2_resume_addr", imem_addr_o, 16'h0008);
        tick();
        chk("t2_pop2", pc_plus2_o, 16'h0006);
        tick();
        chk("t2_pop3", pc_plus2_o, 16'h0008);
        tick();
        chk("t2_drained", 16'(instr_valid_o), 16'h0);

        // redirect while the request to 0x0008 is outstanding
        rst_n = 1'b0; lat = 0; tick();
        rst_n = 1'b1;
        tick(); tick(); tick(); tick();
        chk("t3_addr6", imem_addr_o, 16'h0006);
        tick();
        chk("t3_addr8", imem_addr_o, 16'h0008);
        manual = 1'b1; man_ack = 1'b0; beef_watch = 1'b1;
        redirect_i = 1'b1; redirect_pc_i = 16'h0040;
        tick();
        chk("t3_hold_req", 16'(imem_req_o), 16'h1);
        chk("t3_hold_addr", imem_addr_o, 16'h0008);
        chk("t3_flushed", 16'(instr_valid_o), 16'h0);
        redirect_i = 1'b0;
        tick();
        man_ack = 1'b1; man_data = 16'hBEEF;
        tick();
        chk("t3_new_addr", imem_addr_o, 16'h0040);
        chk("t3_still_empty", 16'(instr_valid_o), 16'h0);
        manual = 1'b0; man_ack = 1'b0;
        tick();
        chk("t3_first_valid", 16'(instr_valid_o), 16'h1);
        chk("t3_first_pc2", pc_plus2_o, 16'h0042);
        chk("t3_first_instr", instr_o, 16'h5A1A);
        tick();
        beef_watch = 1'b0;

        // redirect + pop + ack in one cycle with two buffered entries
        rst_n = 1'b0; tick();
        rst_n = 1'b1; stall_i = 1'b1; lat = 0;
        tick(); tick(); tick();
        chk("t4_two_entries", 16'(m_q.size()), 16'd2);
        stall_i = 1'b0; redirect_i = 1'b1; redirect_pc_i = 16'h0123;
        tick();
        chk("t4_valid", 16'(instr_valid_o), 16'h0);
        chk("t4_instr", instr_o, 16'h0000);
        chk("t4_pc2", pc_plus2_o, 16'h0000);
        chk("t4_addr", imem_addr_o, 16'h0122);
        redirect_i = 1'b0;
        tick();
        chk("t4_after", pc_plus2_o, 16'h0124);

        // address wrap at 0xFFFE
        redirect_i = 1'b1; redirect_pc_i = 16'hFFFE;
        tick();
        chk("t5_addr_fffe", imem_addr_o, 16'hFFFE);
        redirect_i = 1'b0;
        tick();
        chk("t5_addr_wrap", imem_addr_o, 16'h0000);
        chk("t5_pc2_wrap", pc_plus2_o, 16'h0000);
        chk("t5_valid", 16'(instr_valid_o), 16'h1);
        chk("t5_instr", instr_o, 16'hA5A4);

        // reset mid-request with three buffered entries; ack during reset ignored
        rst_n = 1'b0; tick();
        rst_n = 1'b1; stall_i = 1'b1; lat = 0;
        tick(); tick(); tick(); tick();
        chk("t6_three", 16'(m_q.size()), 16'd3);
        manual = 1'b1; man_ack = 1'b0;
        tick();
        rst_n = 1'b0; man_ack = 1'b1; man_data = 16'h1234;
        tick();
        chk("t6_valid", 16'(instr_valid_o), 16'h0);
        chk("t6_req", 16'(imem_req_o), 16'h0);
        chk("t6_addr", imem_addr_o, 16'h0000);
        tick();
        rst_n = 1'b1; manual = 1'b0; man_ack = 1'b0; stall_i = 1'b0;
        tick();
        chk("t6_restart_req", 16'(imem_req_o), 16'h1);
        chk("t6_restart_empty", 16'(instr_valid_o), 16'h0);
        tick();
        chk("t6_first_pc2", pc_plus2_o, 16'h0002);
        chk("t6_first_instr", instr_o, 16'h5A5A);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
